// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with fixed-latency memory sequencing.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module dcache_ctrl #(
  parameter int INDEX_BITS  = 4,
  parameter int MEM_LATENCY = 4
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            req_read,
  input  logic            req_write,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  output logic [31:0]     rdata,
  output logic            ready,
  output logic            hit,
  output logic            stall,
  output logic [31:0]     mem_addr,
  output logic [0:3][7:0] mem_data_in,
  input  logic [0:3][7:0] mem_data_out,
  output logic            mem_write_en,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count
);
  localparam int         LINES = 1 << INDEX_BITS;
  localparam int         TAG_W = 30 - INDEX_BITS;
  localparam logic [3:0] LAST  = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, MEM_READ, MEM_WRITE, DONE} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  wr_hit;
  logic [LINES-1:0]      valid;
  logic [TAG_W-1:0]      tags  [LINES];
  logic [31:0]           lines [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic                  tag_hit;
  logic [INDEX_BITS-1:0] mem_idx;
  logic [TAG_W-1:0]      mem_tag;
  logic                  upd_en;
  logic                  fill_en;
  logic                  unused_addr_bits;

  assign idx              = req_addr[INDEX_BITS+1:2];
  assign tag              = req_addr[31:INDEX_BITS+2];
  assign tag_hit          = valid[idx] && (tags[idx] == tag);
  assign unused_addr_bits = ^req_addr[1:0];

  // During an access the latched word address selects the line, so a requester
  // that drops or changes its request cannot redirect the fill.
  assign mem_idx = mem_addr[INDEX_BITS+1:2];
  assign mem_tag = mem_addr[31:INDEX_BITS+2];

  assign stall   = (req_read | req_write) & ~ready;
  assign upd_en  = rst_b && (state == IDLE) && req_write && tag_hit;
  assign fill_en = rst_b && (state == MEM_READ) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (upd_en) lines[idx] <= req_wdata;
    if (fill_en) begin
      lines[mem_idx] <= mem_data_out;
      tags[mem_idx]  <= mem_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state        <= IDLE;
      cnt          <= '0;
      wr_hit       <= 1'b0;
      valid        <= '0;
      rdata        <= '0;
      ready        <= 1'b0;
      hit          <= 1'b0;
      mem_addr     <= '0;
      mem_data_in  <= '0;
      mem_write_en <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req_write) begin
            state        <= MEM_WRITE;
            mem_addr     <= {req_addr[31:2], 2'b00};
            mem_data_in  <= req_wdata;
            mem_write_en <= 1'b1;
            wr_hit       <= tag_hit;
          end else if (req_read && tag_hit) begin
            state <= DONE;
            rdata <= lines[idx];
            hit   <= 1'b1;
            ready <= 1'b1;
          end else if (req_read) begin
            state    <= MEM_READ;
            mem_addr <= {req_addr[31:2], 2'b00};
          end
        end
        MEM_READ: begin
          if (cnt == LAST) begin
            state          <= DONE;
            rdata          <= mem_data_out;
            valid[mem_idx] <= 1'b1;
            hit            <= 1'b0;
            ready          <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        MEM_WRITE: begin
          mem_write_en <= 1'b0;
          if (cnt == LAST) begin
            state <= DONE;
            hit   <= wr_hit;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b0;
          hit   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == DONE) begin
      if (hit) begin
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule
